game_sequencer: RTL and testbench

Top-level game-flow controller for the dino runner. It sequences the obstacle scroller and the collision checker: it decides when obstacles scroll and at what speed, and it turns the collision checker's freeze flag into a death sequence and game-over. It also keeps score and high score in BCD for the seven-segment display. It sits between the button inputs, the VGA frame strobe, the obstacle generator (s1..s6) and the collision logic.

---
 rtl/game_pkg.sv | 14 +
 rtl/game_sequencer_bcd_counter4.sv | 41 ++++
 rtl/game_sequencer.sv | 138 +++++++++++++
 tb/tb_game_sequencer.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// Shared definitions for the dino-runner game-flow controller.
package game_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DYING = 2'd2,
    ST_OVER  = 2'd3
  } state_t;

  localparam int              BCD_W     = 16;
  localparam logic [BCD_W-1:0] SCORE_MAX = 16'h9999;

endpackage

// File: rtl/game_sequencer_bcd_counter4.sv
// Four-digit BCD up-counter that sticks at 9999 instead of wrapping.
module bcd_counter4
  import game_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [BCD_W-1:0] value
);

  logic [BCD_W-1:0] r_val;
  logic [BCD_W-1:0] w_next;

  // Ripple a +1 through the digits: each 9 rolls to 0 and carries on.
  always_comb begin
    logic v_c;
    w_next = r_val;
    v_c    = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (v_c) begin
        if (r_val[i*4 +: 4] == 4'd9) begin
          w_next[i*4 +: 4] = 4'd0;
        end else begin
          w_next[i*4 +: 4] = r_val[i*4 +: 4] + 4'd1;
          v_c              = 1'b0;
        end
      end
    end
  end

  // Clear has priority over increment; increments at 9999 are dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                            r_val <= '0;
    else if (clr)                       r_val <= '0;
    else if (inc && r_val != SCORE_MAX) r_val <= w_next;
  end

  assign value = r_val;

endmodule

// File: rtl/game_sequencer.sv
// Game-flow controller: start/run/death/game-over sequencing, scroll speed,
// BCD score and high score.
module game_sequencer
  import game_pkg::*;
#(
  parameter int FRAMES_PER_POINT = 6,
  parameter int SPEED_STEP       = 100,
  parameter int MIN_SPEED        = 2,
  parameter int MAX_SPEED        = 8,
  parameter int DEATH_FRAMES     = 60,
  parameter int SPEED_W          = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_btn,
  input  logic               frame_tick,
  input  logic               freeze,
  output logic [1:0]         state,
  output logic               run_en,
  output logic               clear_pulse,
  output logic [SPEED_W-1:0] speed,
  output logic [BCD_W-1:0]   score,
  output logic [BCD_W-1:0]   hi_score,
  output logic               flash
);

  localparam int FC_W = (FRAMES_PER_POINT > 1) ? $clog2(FRAMES_PER_POINT) : 1;
  localparam int PC_W = (SPEED_STEP > 1)       ? $clog2(SPEED_STEP)       : 1;
  localparam int DC_W = (DEATH_FRAMES > 1)     ? $clog2(DEATH_FRAMES)     : 1;

  state_t             r_state;
  logic               r_sync1, r_sync2, r_sync3;
  logic [FC_W-1:0]    r_frame_cnt;
  logic [PC_W-1:0]    r_pts_cnt;
  logic [DC_W-1:0]    r_death_cnt;
  logic [2:0]         r_flash_cnt;
  logic               r_clear_pulse;
  logic               r_flash;
  logic [SPEED_W-1:0] r_speed;
  logic [BCD_W-1:0]   r_hi_score;

  logic               w_start_rise;
  logic               w_go;
  logic               w_point;
  logic [BCD_W-1:0]   w_score;

  // Two-flop synchroniser plus one history flop for rising-edge detect.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) {r_sync3, r_sync2, r_sync1} <= 3'b000;
    else     {r_sync3, r_sync2, r_sync1} <= {r_sync2, r_sync1, start_btn};
  end

  assign w_start_rise = r_sync2 & ~r_sync3;
  assign w_go         = ((r_state == ST_IDLE) || (r_state == ST_OVER)) && w_start_rise;
  // A point is earned on the last frame of a period, unless a collision
  // lands in the same cycle (collision wins, nothing advances).
  assign w_point      = (r_state == ST_RUN) && frame_tick && !freeze &&
                        (r_frame_cnt == FC_W'(FRAMES_PER_POINT - 1));

  bcd_counter4 u_score (
    .clk   (clk),
    .rst   (rst),
    .clr   (w_go),
    .inc   (w_point),
    .value (w_score)
  );

  // Game FSM with its registered side outputs and frame/point/death counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= ST_IDLE;
      r_clear_pulse <= 1'b0;
      r_frame_cnt   <= '0;
      r_pts_cnt     <= '0;
      r_death_cnt   <= '0;
      r_flash_cnt   <= '0;
      r_flash       <= 1'b0;
      r_speed       <= SPEED_W'(MIN_SPEED);
      r_hi_score    <= '0;
    end else begin
      r_clear_pulse <= 1'b0;
      case (r_state)
        ST_IDLE, ST_OVER: begin
          if (w_start_rise) begin
            r_state       <= ST_RUN;
            r_clear_pulse <= 1'b1;
            r_frame_cnt   <= '0;
            r_pts_cnt     <= '0;
            r_speed       <= SPEED_W'(MIN_SPEED);
          end
        end
        ST_RUN: begin
          if (freeze) begin
            r_state     <= ST_DYING;
            r_death_cnt <= '0;
            r_flash_cnt <= '0;
            r_flash     <= 1'b1;
            if (w_score > r_hi_score) r_hi_score <= w_score;
          end else if (frame_tick) begin
            if (w_point) begin
              r_frame_cnt <= '0;
              if (r_pts_cnt == PC_W'(SPEED_STEP - 1)) begin
                r_pts_cnt <= '0;
                if (r_speed < SPEED_W'(MAX_SPEED)) r_speed <= r_speed + 1'b1;
              end else begin
                r_pts_cnt <= r_pts_cnt + 1'b1;
              end
            end else begin
              r_frame_cnt <= r_frame_cnt + 1'b1;
            end
          end
        end
        ST_DYING: begin
          if (frame_tick) begin
            if (r_death_cnt == DC_W'(DEATH_FRAMES - 1)) begin
              r_state <= ST_OVER;
              r_flash <= 1'b0;
            end else begin
              r_death_cnt <= r_death_cnt + 1'b1;
              r_flash_cnt <= r_flash_cnt + 1'b1;
              if (r_flash_cnt == 3'd7) r_flash <= ~r_flash;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign state       = r_state;
  assign run_en      = (r_state == ST_RUN);
  assign clear_pulse = r_clear_pulse;
  assign speed       = r_speed;
  assign score       = w_score;
  assign hi_score    = r_hi_score;
  assign flash       = r_flash;

endmodule

// File: tb/tb_game_sequencer.sv
// Directed bench for game_sequencer: start sync, scoring, speed ramp,
// saturation, death sequence, restart and async reset.
module tb_game_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_btn;
  logic        frame_tick;
  logic        freeze;
  logic [1:0]  state;
  logic        run_en;
  logic        clear_pulse;
  logic [3:0]  speed;
  logic [15:0] score;
  logic [15:0] hi_score;
  logic        flash;

  int n_checks = 0;
  int n_err    = 0;

  game_sequencer dut (
    .clk         (clk),
    .rst         (rst),
    .start_btn   (start_btn),
    .frame_tick  (frame_tick),
    .freeze      (freeze),
    .state       (state),
    .run_en      (run_en),
    .clear_pulse (clear_pulse),
    .speed       (speed),
    .score       (score),
    .hi_score    (hi_score),
    .flash       (flash)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Hold frame_tick high for n rising edges; returns on a falling edge.
  task automatic tick_n(input int n);
    frame_tick = 1'b1;
    repeat (n) @(negedge clk);
    frame_tick = 1'b0;
  endtask

  // Press start for 5 cycles and watch for exactly one clear pulse.
  task automatic do_start(input string tag);
    int cnt = 0;
    int at  = 0;
    start_btn = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (i == 5) start_btn = 1'b0;
      if (clear_pulse) begin
        cnt++;
        at = i;
      end
    end
    chk({tag, "_clr_cnt"}, cnt, 1);
    chk({tag, "_clr_lat"}, ((at >= 3) && (at <= 4)) ? 1 : 0, 1);
    chk({tag, "_state"}, state, 1);
    chk({tag, "_run_en"}, run_en, 1);
    chk({tag, "_speed"}, speed, 2);
    chk({tag, "_score"}, score, 16'h0000);
  endtask

  initial begin
    rst        = 1'b1;
    start_btn  = 1'b0;
    frame_tick = 1'b0;
    freeze     = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_state", state, 0);
    chk("rst_run_en", run_en, 0);
    chk("rst_clear", clear_pulse, 0);
    chk("rst_speed", speed, 2);
    chk("rst_score", score, 0);
    chk("rst_hi", hi_score, 0);
    chk("rst_flash", flash, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("idle_state", state, 0);

    // Game 1: reach 42 points, then collide on a point-earning tick.
    do_start("g1");
    tick_n(252);
    chk("g1_score42", score, 16'h0042);
    tick_n(5);
    chk("g1_score42b", score, 16'h0042);
    frame_tick = 1'b1;
    freeze     = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
    chk("die_state", state, 2);
    chk("die_score", score, 16'h0042);
    chk("die_hi", hi_score, 16'h0042);
    chk("die_run_en", run_en, 0);
    chk("die_flash", flash, 1);

    // Start and freeze are both ignored while dying.
    start_btn = 1'b1;
    repeat (5) @(negedge clk);
    start_btn = 1'b0;
    repeat (3) @(negedge clk);
    chk("die_ign_start", state, 2);
    chk("die_no_clear", clear_pulse, 0);
    tick_n(8);
    chk("die_flash8", flash, 0);
    tick_n(51);
    chk("die_59", state, 2);
    tick_n(1);
    chk("over_state", state, 3);
    chk("over_flash", flash, 0);
    repeat (3) @(negedge clk);
    chk("over_hold", state, 3);
    chk("over_score", score, 16'h0042);
    freeze = 1'b0;

    // Game 2: restart keeps the high score, then ramp speed and saturate.
    do_start("g2");
    chk("g2_hi", hi_score, 16'h0042);
    tick_n(599);
    chk("g2_s99", score, 16'h0099);
    chk("g2_sp2", speed, 2);
    tick_n(1);
    chk("g2_s100", score, 16'h0100);
    chk("g2_sp3", speed, 3);
    tick_n(3000);
    chk("g2_s600", score, 16'h0600);
    chk("g2_sp8", speed, 8);
    tick_n(600);
    chk("g2_s700", score, 16'h0700);
    chk("g2_sp8hold", speed, 8);
    tick_n(55788);
    chk("g2_s9998", score, 16'h9998);
    tick_n(12);
    chk("g2_s9999", score, 16'h9999);
    tick_n(6);
    chk("g2_s9999hold", score, 16'h9999);
    chk("g2_state", state, 1);

    // Asynchronous reset between clock edges.
    #2 rst = 1'b1;
    #1;
    chk("arst_state", state, 0);
    chk("arst_run_en", run_en, 0);
    chk("arst_clear", clear_pulse, 0);
    chk("arst_speed", speed, 2);
    chk("arst_score", score, 0);
    chk("arst_hi", hi_score, 0);
    chk("arst_flash", flash, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
